// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Frame-capture controller on the clk_data domain. Decodes DVI control
//   tokens on channel 0 to recover VSYNC and DE. Forwards active-video words
//   with start-of-frame/line tags, either one frame or continuously, always
//   aligned to VSYNC. Measures frame geometry and abandons a frame cleanly
//   when the sink stalls.
// Ports
//   clk, rst         capture clock, synchronous active-high reset
//   in_valid/in_data 30-bit {ch2,ch1,ch0} TMDS symbols, bubbles allowed
//   arm, cont, stop  start capture (cont sampled with arm) / finish and stop
//   out_ready        sink accepts a word this cycle
//   out_valid/out_data/out_sof/out_sol  forwarded DE words, 2-cycle latency
//   busy             sequencer not idle
//   frame_done       1-cycle pulse per completely forwarded frame
//   overflow         sticky sink stall flag, cleared by arm
//   line_len, frame_lines, geom_err  geometry of the last good frame
module capture_sequencer #(
    parameter int   CNT_W  = 12,
    parameter logic VS_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [29:0]      in_data,
    input  logic             arm,
    input  logic             cont,
    input  logic             stop,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [29:0]      out_data,
    output logic             out_sof,
    output logic             out_sol,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines,
    output logic             geom_err
);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_VBLANK,
        S_ACTIVE,
        S_DROP
    } state_t;

    state_t state, state_nxt;

    // stage 1
    logic        is_ctrl, c1, vs_on, vs_next;
    logic        s1_valid, s1_de, s1_vs_rise, s1_vs_fall;
    logic [29:0] s1_data;
    logic        prev_de;

    // control
    logic cont_q, stop_pend, sof_pend;
    logic take_arm, fire_done, ovf_evt, emit, stop_now;

    // geometry
    logic [CNT_W-1:0] pix_cnt, line_cnt, first_len, last_len, len_eff;
    logic             err_acc, err_eff, de_fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        is_ctrl = 1'b1;
        c1      = 1'b0;
        case (in_data[9:0])
            TOK_00:  c1 = 1'b0;
            TOK_01:  c1 = 1'b0;
            TOK_10:  c1 = 1'b1;
            TOK_11:  c1 = 1'b1;
            default: is_ctrl = 1'b0;
        endcase
    end

    // VSYNC level only moves on valid control tokens; data words hold it.
    assign vs_next = (in_valid && is_ctrl) ? (c1 == VS_POL) : vs_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_on      <= 1'b0;
            s1_valid   <= 1'b0;
            s1_de      <= 1'b0;
            s1_data    <= '0;
            s1_vs_rise <= 1'b0;
            s1_vs_fall <= 1'b0;
            prev_de    <= 1'b0;
        end else begin
            vs_on      <= vs_next;
            s1_valid   <= in_valid;
            s1_de      <= in_valid & ~is_ctrl;
            s1_data    <= in_data;
            s1_vs_rise <= in_valid & vs_next & ~vs_on;
            s1_vs_fall <= in_valid & ~vs_next & vs_on;
            if (s1_valid) prev_de <= s1_de;
        end
    end

    assign busy     = (state != S_IDLE);
    assign de_fall  = s1_valid & ~s1_de & prev_de;
    assign stop_now = stop_pend | stop;
    assign ovf_evt  = (state == S_ACTIVE) & out_valid & ~out_ready;
    // The stalled cycle also suppresses the word behind it, so nothing more
    // of the aborted frame reaches the sink.
    assign emit     = s1_valid & s1_de & (state == S_ACTIVE) & ~ovf_evt;

    // A frame's last line may end on the very token that raises VSYNC, so
    // the geometry latched at frame end folds in a DE fall on that word.
    assign len_eff = de_fall ? pix_cnt : last_len;
    assign err_eff = err_acc |
                     (de_fall && (line_cnt != CNT_ONE) && (pix_cnt != first_len));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take_arm  = 1'b0;
        fire_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    take_arm  = 1'b1;
                    state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                if (stop)            state_nxt = S_IDLE;
                else if (s1_vs_rise) state_nxt = S_VBLANK;
            end
            S_VBLANK: begin
                if (stop)            state_nxt = S_IDLE;
                else if (s1_vs_fall) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (ovf_evt) begin
                    state_nxt = S_DROP;
                end else if (s1_vs_rise) begin
                    fire_done = 1'b1;
                    state_nxt = (cont_q && !stop_now) ? S_VBLANK : S_IDLE;
                end
            end
            S_DROP: begin
                if (s1_vs_rise) state_nxt = (cont_q && !stop_now) ? S_VBLANK : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cont_q    <= 1'b0;
            stop_pend <= 1'b0;
            overflow  <= 1'b0;
            sof_pend  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_sol   <= 1'b0;
        end else begin
            if (take_arm) begin
                cont_q    <= cont;
                stop_pend <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (busy && stop) stop_pend <= 1'b1;
                if (ovf_evt)      overflow  <= 1'b1;
            end
            if (state == S_VBLANK) sof_pend <= 1'b1;
            else if (emit)         sof_pend <= 1'b0;
            out_valid <= emit;
            out_data  <= s1_data;
            out_sof   <= emit & sof_pend;
            out_sol   <= emit & ~prev_de;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt     <= '0;
            line_cnt    <= '0;
            first_len   <= '0;
            last_len    <= '0;
            err_acc     <= 1'b0;
            frame_done  <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
            geom_err    <= 1'b0;
        end else begin
            frame_done <= fire_done;
            if (state == S_VBLANK) begin
                pix_cnt   <= '0;
                line_cnt  <= '0;
                first_len <= '0;
                last_len  <= '0;
                err_acc   <= 1'b0;
            end else if (state == S_ACTIVE && s1_valid) begin
                if (s1_de) begin
                    pix_cnt <= sat_inc(pix_cnt);
                    if (!prev_de) line_cnt <= sat_inc(line_cnt);
                end else if (prev_de) begin
                    last_len <= pix_cnt;
                    pix_cnt  <= '0;
                    if (line_cnt == CNT_ONE)     first_len <= pix_cnt;
                    else if (pix_cnt != first_len) err_acc <= 1'b1;
                end
            end
            if (fire_done) begin
                line_len    <= len_eff;
                frame_lines <= line_cnt;
                geom_err    <= err_eff;
            end
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer
//   Directed bench for capture_sequencer: drives DVI token/pixel streams,
//   predicts forwarded words (data, tags, arrival cycle) into a queue and
//   checks geometry, status flags and frame_done pulse counts.
module tb_capture_sequencer;

    localparam int CNT_W = 12;
    localparam logic [29:0] T00 = {20'h0, 10'b1101010100};
    localparam logic [29:0] T10 = {20'h0, 10'b0101010100};

    logic             clk, rst, in_valid, arm, cont, stop, out_ready;
    logic [29:0]      in_data;
    logic             out_valid, out_sof, out_sol, busy, frame_done, overflow, geom_err;
    logic [29:0]      out_data;
    logic [CNT_W-1:0] line_len, frame_lines;

    capture_sequencer #(.CNT_W(CNT_W), .VS_POL(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .arm(arm), .cont(cont), .stop(stop), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
        .out_sol(out_sol), .busy(busy), .frame_done(frame_done),
        .overflow(overflow), .line_len(line_len), .frame_lines(frame_lines),
        .geom_err(geom_err)
    );

    typedef struct {
        logic [29:0] d;
        logic        sof;
        logic        sol;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned done_base;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every forwarded word must match the queue head,
    // including the cycle it was predicted to arrive in.
    always @(negedge clk) begin
        exp_t e;
        if (frame_done === 1'b1) done_cnt++;
        if (out_valid !== 1'b0) begin
            chk("word_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_sof", 32'(out_sof), 32'(e.sof));
                chk("out_sol", 32'(out_sol), 32'(e.sol));
                chk("latency", cyc, e.cyc);
            end
        end
    end

    function automatic logic [29:0] pix(input int w);
        logic [31:0] r;
        r = $urandom();
        return {r[19:0], 4'hF, w[5:0]};
    endfunction

    // One input slot; pulses default low and out_ready high each slot.
    task automatic slot(input logic v, input logic [29:0] d, input bit push,
                        input bit sof, input bit sol);
        @(posedge clk);
        #1;
        rst = 1'b0; arm = 1'b0; stop = 1'b0; out_ready = 1'b1;
        in_valid = v;
        in_data  = d;
        if (push) sb.push_back('{d, sof, sol, cyc + 2});
    endtask

    task automatic tok(input logic [29:0] t, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) slot(1'b1, t, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vs_start();
        tok(T10, 3);
        tok(T00, 3);
    endtask

    task automatic lines(input int nl, input int len, input int last_len, input bit cap,
                         input int stop_line, input int drop_word, input bit bub);
        int w = 0;
        for (int l = 0; l < nl; l++) begin
            int n = (l == nl - 1) ? last_len : len;
            slot(1'b1, T00, 1'b0, 1'b0, 1'b0);
            if (l == stop_line) stop = 1'b1;
            slot(1'b1, T00, 1'b0, 1'b0, 1'b0);
            for (int p = 0; p < n; p++) begin
                logic [29:0] d;
                bit          push;
                if (bub) begin
                    // Invalid slots carry a VSYNC token that must be ignored.
                    while ($urandom_range(1, 0) == 1) slot(1'b0, T10, 1'b0, 1'b0, 1'b0);
                end
                d    = pix(w);
                push = cap && (drop_word < 0 || w <= drop_word);
                slot(1'b1, d, push, w == 0, p == 0);
                if (drop_word >= 0 && w == drop_word + 2) out_ready = 1'b0;
                w++;
            end
        end
        tok(T00, 2);
    endtask

    task automatic check_geom(input string t, input int len, input int nl, input bit err);
        chk({t, "_line_len"}, 32'(line_len), 32'(len));
        chk({t, "_frame_lines"}, 32'(frame_lines), 32'(nl));
        chk({t, "_geom_err"}, 32'(geom_err), 32'(err));
    endtask

    task automatic check_all_zero(input string t);
        chk({t, "_out_valid"}, 32'(out_valid), 0);
        chk({t, "_out_data"}, 32'(out_data), 0);
        chk({t, "_out_sof"}, 32'(out_sof), 0);
        chk({t, "_out_sol"}, 32'(out_sol), 0);
        chk({t, "_busy"}, 32'(busy), 0);
        chk({t, "_frame_done"}, 32'(frame_done), 0);
        chk({t, "_overflow"}, 32'(overflow), 0);
        check_geom(t, 0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        arm = 1'b0; cont = 1'b0; stop = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // T1: single 4x3 frame
        slot(1'b1, T00, 1'b0, 1'b0, 1'b0);
        arm = 1'b1; cont = 1'b0;
        slot(1'b1, T00, 1'b0, 1'b0, 1'b0);
        chk("t1_busy_armed", 32'(busy), 1);
        done_base = done_cnt;
        vs_start();
        lines(3, 4, 4, 1'b1, -1, -1, 1'b0);
        tok(T10, 3);
        tok(T00, 4);
        chk("t1_frame_done", done_cnt - done_base, 1);
        check_geom("t1", 4, 3, 1'b0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_sb_empty", 32'(sb.size()), 0);

        // T2: continuous, arm+stop together (stop ignored), stop in frame 2
        slot(1'b1, T00, 1'b0, 1'b0, 1'b0);
        arm = 1'b1; cont = 1'b1; stop = 1'b1;
        done_base = done_cnt;
        vs_start();
        lines(3, 4, 4, 1'b1, -1, -1, 1'b0);
        vs_start();
        lines(3, 4, 4, 1'b1, 1, -1, 1'b0);
        vs_start();
        chk("t2_busy_frame3", 32'(busy), 0);
        lines(3, 4, 4, 1'b0, -1, -1, 1'b0);
        tok(T00, 4);
        chk("t2_frame_done", done_cnt - done_base, 2);
        chk("t2_sb_empty", 32'(sb.size()), 0);

        // T3: sink stall on 5th word, next frame captured
        slot(1'b1, T00, 1'b0, 1'b0, 1'b0);
        arm = 1'b1; cont = 1'b1;
        done_base = done_cnt;
        vs_start();
        lines(3, 4, 4, 1'b1, -1, 4, 1'b0);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_busy_drop", 32'(busy), 1);
        chk("t3_no_done", done_cnt - done_base, 0);
        vs_start();
        lines(3, 4, 4, 1'b1, -1, -1, 1'b0);
        tok(T10, 3);
        slot(1'b1, T10, 1'b0, 1'b0, 1'b0);
        stop = 1'b1;
        tok(T00, 4);
        chk("t3_frame_done", done_cnt - done_base, 1);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_overflow_sticky", 32'(overflow), 1);
        check_geom("t3", 4, 3, 1'b0);
        chk("t3_sb_empty", 32'(sb.size()), 0);

        // T4: unequal line lengths
        slot(1'b1, T00, 1'b0, 1'b0, 1'b0);
        arm = 1'b1; cont = 1'b0;
        slot(1'b1, T00, 1'b0, 1'b0, 1'b0);
        chk("t4_overflow_cleared", 32'(overflow), 0);
        done_base = done_cnt;
        vs_start();
        lines(3, 4, 5, 1'b1, -1, -1, 1'b0);
        tok(T10, 3);
        tok(T00, 4);
        chk("t4_frame_done", done_cnt - done_base, 1);
        check_geom("t4", 5, 3, 1'b1);
        chk("t4_sb_empty", 32'(sb.size()), 0);

        // T5: random input bubbles
        slot(1'b1, T00, 1'b0, 1'b0, 1'b0);
        arm = 1'b1; cont = 1'b0;
        done_base = done_cnt;
        vs_start();
        lines(3, 4, 4, 1'b1, -1, -1, 1'b1);
        tok(T10, 3);
        tok(T00, 4);
        chk("t5_frame_done", done_cnt - done_base, 1);
        check_geom("t5", 4, 3, 1'b0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_sb_empty", 32'(sb.size()), 0);

        // T6: reset in the middle of ACTIVE, then a fresh capture
        slot(1'b1, T00, 1'b0, 1'b0, 1'b0);
        arm = 1'b1; cont = 1'b0;
        done_base = done_cnt;
        vs_start();
        tok(T00, 2);
        for (int w = 0; w < 4; w++) slot(1'b1, pix(w), w < 3, w == 0, w == 0);
        slot(1'b1, pix(4), 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("t6_reset");
        tok(T00, 2);
        chk("t6_sb_empty_rst", 32'(sb.size()), 0);
        chk("t6_no_done", done_cnt - done_base, 0);
        slot(1'b1, T00, 1'b0, 1'b0, 1'b0);
        arm = 1'b1; cont = 1'b0;
        vs_start();
        lines(3, 4, 4, 1'b1, -1, -1, 1'b0);
        tok(T10, 3);
        tok(T00, 4);
        chk("t6_frame_done", done_cnt - done_base, 1);
        check_geom("t6", 4, 3, 1'b0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
